// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the loop sequencer: FSM state encoding, registered
// status bundle and the reset-state constants.
package loop_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    typedef struct packed {
        logic fsm_start;
        logic busy;
        logic done;
        logic err;
    } status_t;

    localparam state_t  RESET_STATE  = ST_IDLE;
    localparam status_t RESET_STATUS = '0;

    // Status flags are a pure function of the state being entered, so they can be
    // registered alongside the state itself.
    function automatic status_t decode_status(input state_t s);
        status_t st;
        st           = RESET_STATUS;
        st.fsm_start = (s == ST_LAUNCH);
        st.busy      = (s == ST_LAUNCH) || (s == ST_RUN);
        st.done      = (s == ST_DONE);
        st.err       = (s == ST_ERR);
        return st;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// Sequences a controlled FSM through trip_count loop-body passes, counting its
// branch evaluations and run cycles, with abort and a RUN-state timeout.
module loop_sequencer
    import loop_ctrl_pkg::*;
#(
    parameter int TRIP_W  = 8,
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic [TRIP_W-1:0] trip_count,
    output logic              fsm_start,
    output logic              fsm_branch,
    input  logic              fsm_eval,
    input  logic              fsm_finish,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TRIP_W-1:0] iter_count,
    output logic [CYC_W-1:0]  cycle_count
);

    // The RUN cycle whose closing edge brings cycle_count up to TIMEOUT.
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    status_t           status_q;
    status_t           status_next;
    logic [TRIP_W-1:0] rem;
    logic              go_accept;
    logic              run_active;
    logic              timeout_hit;

    assign go_accept   = (state == ST_IDLE) && go && !abort;
    assign run_active  = (state == ST_RUN) && !abort;
    assign timeout_hit = (cycle_count >= TIMEOUT_LAST);

    // State register; the status flags are registered here too so no output
    // is a decode of live logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            status_q <= RESET_STATUS;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state    <= next_state;
            status_q <= status_next;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (latch).
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go) next_state = (trip_count != '0) ? ST_LAUNCH : ST_DONE;
                end
                ST_LAUNCH: next_state = ST_RUN;
                ST_RUN: begin
                    if (fsm_finish)       next_state = ST_DONE;
                    else if (timeout_hit) next_state = ST_ERR;
                end
                ST_DONE: next_state = ST_IDLE;
                ST_ERR:  next_state = ST_ERR;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status_next = decode_status(next_state);
    end

    assign fsm_start = status_q.fsm_start;
    assign busy      = status_q.busy;
    assign done      = status_q.done;
    assign err       = status_q.err;

    // Loop bookkeeping: remaining passes, evaluation count and the branch flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem        <= '0;
            iter_count <= '0;
            fsm_branch <= 1'b0;
        end else begin
            fsm_branch <= (rem > TRIP_W'(1));
            if (abort) begin
                rem <= '0;
            end else if (go_accept) begin
                rem        <= trip_count;
                iter_count <= '0;
            end else if (run_active && fsm_eval) begin
                if (rem != '0)         rem        <= rem - 1'b1;
                if (iter_count != '1)  iter_count <= iter_count + 1'b1;
            end
        end
    end

    sat_counter #(
        .W(CYC_W)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clear (go_accept),
        .inc   (run_active),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: directed scenarios plus randomized runs
// checked against an expected schedule computed from the loop rules.
module tb_loop_sequencer;

    localparam int TRIP_W  = 8;
    localparam int CYC_W   = 16;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic              abort;
    logic [TRIP_W-1:0] trip_count;
    logic              fsm_start;
    logic              fsm_branch;
    logic              fsm_eval;
    logic              fsm_finish;
    logic              busy;
    logic              done;
    logic              err;
    logic [TRIP_W-1:0] iter_count;
    logic [CYC_W-1:0]  cycle_count;
    logic [3:0]        status;

    int vectors     = 0;
    int miscompares = 0;
    int start_cnt   = 0;
    int done_cnt    = 0;

    loop_sequencer #(
        .TRIP_W (TRIP_W),
        .CYC_W  (CYC_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .abort      (abort),
        .trip_count (trip_count),
        .fsm_start  (fsm_start),
        .fsm_branch (fsm_branch),
        .fsm_eval   (fsm_eval),
        .fsm_finish (fsm_finish),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .iter_count (iter_count),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    assign status = {fsm_start, busy, done, err};

    // Free-running pulse tallies; scenarios compare deltas.
    always @(negedge clk) begin
        if (fsm_start === 1'b1) start_cnt++;
        if (done === 1'b1)      done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; abort = 1'b0; fsm_eval = 1'b0; fsm_finish = 1'b0;
        trip_count = '0;
        step(); step();
        vectors++;
        if (status !== 4'b0000 || fsm_branch !== 1'b0 || iter_count !== '0 || cycle_count !== '0) begin
            miscompares++;
            $display("FAIL reset_during: status=%b branch=%b iter=%0d cyc=%0d want 0000/0/0/0",
                     status, fsm_branch, iter_count, cycle_count);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (status !== 4'b0000 || fsm_branch !== 1'b0 || iter_count !== '0 || cycle_count !== '0) begin
            miscompares++;
            $display("FAIL reset_after: status=%b branch=%b iter=%0d cyc=%0d want 0000/0/0/0",
                     status, fsm_branch, iter_count, cycle_count);
        end
    endtask

    // One complete run. Evals land on RUN cycles gap, 2*gap, ...; finish lands on
    // the last eval cycle or the cycle after it.
    task automatic do_run(input int trip, input int n_ev, input int gap, input bit fin_eval,
                          input bit poke_go, input string tag);
        int fin_cyc;
        int evs;
        int s0;
        int exp_iter;
        bit ev;
        fin_cyc = (n_ev == 0) ? 1 : (fin_eval ? n_ev * gap : n_ev * gap + 1);
        s0  = start_cnt;
        evs = 0;
        trip_count = TRIP_W'(trip);
        go = 1'b1;
        step();
        go = 1'b0;
        trip_count = TRIP_W'($urandom);
        vectors++;
        if (status !== 4'b1100 || iter_count !== '0 || cycle_count !== '0) begin
            miscompares++;
            $display("FAIL %s launch: status=%b iter=%0d cyc=%0d want 1100/0/0",
                     tag, status, iter_count, cycle_count);
        end
        step();
        for (int cyc = 1; cyc <= fin_cyc; cyc++) begin
            vectors++;
            if (status !== 4'b0100 || cycle_count !== CYC_W'(cyc - 1)) begin
                miscompares++;
                $display("FAIL %s run_cycle%0d: status=%b cyc=%0d want 0100/%0d",
                         tag, cyc, status, cycle_count, cyc - 1);
            end
            ev = ((cyc % gap) == 0) && ((cyc / gap) <= n_ev);
            if (ev) begin
                vectors++;
                if (fsm_branch !== ((trip - evs) > 1)) begin
                    miscompares++;
                    $display("FAIL %s branch_eval%0d: got %b want %b",
                             tag, evs + 1, fsm_branch, ((trip - evs) > 1));
                end
                evs++;
            end
            fsm_eval   = ev;
            fsm_finish = (cyc == fin_cyc);
            go         = poke_go && (cyc == 2);
            trip_count = TRIP_W'($urandom);
            step();
            fsm_eval = 1'b0; fsm_finish = 1'b0; go = 1'b0;
        end
        exp_iter = (evs > 255) ? 255 : evs;
        vectors++;
        if (status !== 4'b0010 || iter_count !== TRIP_W'(exp_iter) || cycle_count !== CYC_W'(fin_cyc)) begin
            miscompares++;
            $display("FAIL %s done: status=%b iter=%0d cyc=%0d want 0010/%0d/%0d",
                     tag, status, iter_count, cycle_count, exp_iter, fin_cyc);
        end
        go = poke_go;
        step();
        go = 1'b0;
        vectors++;
        if (status !== 4'b0000 || iter_count !== TRIP_W'(exp_iter) || cycle_count !== CYC_W'(fin_cyc)) begin
            miscompares++;
            $display("FAIL %s idle_hold: status=%b iter=%0d cyc=%0d want 0000/%0d/%0d",
                     tag, status, iter_count, cycle_count, exp_iter, fin_cyc);
        end
        vectors++;
        if (start_cnt - s0 !== 1) begin
            miscompares++;
            $display("FAIL %s start_pulses: got %0d want 1", tag, start_cnt - s0);
        end
    endtask

    task automatic test_basic();
        do_run(3, 3, 4, 1'b0, 1'b0, "basic_trip3");
    endtask

    task automatic test_zero_trip();
        int s0;
        s0 = start_cnt;
        trip_count = '0;
        go = 1'b1;
        step();
        go = 1'b0;
        vectors++;
        if (status !== 4'b0010 || iter_count !== '0 || cycle_count !== '0) begin
            miscompares++;
            $display("FAIL zero_trip_done: status=%b iter=%0d cyc=%0d want 0010/0/0",
                     status, iter_count, cycle_count);
        end
        step();
        vectors++;
        if (status !== 4'b0000 || start_cnt - s0 !== 0) begin
            miscompares++;
            $display("FAIL zero_trip_idle: status=%b starts=%0d want 0000/0", status, start_cnt - s0);
        end
    endtask

    task automatic test_same_cycle();
        do_run(2, 2, 3, 1'b1, 1'b0, "eval_with_finish");
    endtask

    task automatic test_timeout();
        int s0;
        s0 = start_cnt;
        trip_count = 8'd2;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
            vectors++;
            if (status !== 4'b0100) begin
                miscompares++;
                $display("FAIL timeout_run%0d: status=%b want 0100", cyc, status);
            end
            step();
        end
        vectors++;
        if (status !== 4'b0001 || cycle_count !== CYC_W'(TIMEOUT) || iter_count !== '0) begin
            miscompares++;
            $display("FAIL timeout_err: status=%b cyc=%0d iter=%0d want 0001/%0d/0",
                     status, cycle_count, iter_count, TIMEOUT);
        end
        for (int k = 0; k < 4; k++) begin
            go = 1'b1;
            trip_count = TRIP_W'($urandom_range(1, 200));
            step();
            vectors++;
            if (status !== 4'b0001) begin
                miscompares++;
                $display("FAIL err_hold%0d: status=%b want 0001", k, status);
            end
        end
        go = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if (status !== 4'b0000 || start_cnt - s0 !== 1) begin
            miscompares++;
            $display("FAIL err_abort: status=%b starts=%0d want 0000/1", status, start_cnt - s0);
        end
    endtask

    task automatic test_abort_run();
        int d0;
        d0 = done_cnt;
        trip_count = 8'd3;
        go = 1'b1;
        step();
        go = 1'b0;
        step(); step(); step();
        abort = 1'b1;
        fsm_finish = 1'b1;
        step();
        abort = 1'b0;
        fsm_finish = 1'b0;
        vectors++;
        if (status !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_over_finish: status=%b want 0000", status);
        end
        step();
        vectors++;
        if (status !== 4'b0000 || done_cnt - d0 !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: status=%b dones=%0d want 0000/0", status, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_run();
        int d0;
        d0 = done_cnt;
        trip_count = 8'd4;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        #1;
        vectors++;
        if (status !== 4'b0000 || fsm_branch !== 1'b0 || iter_count !== '0 || cycle_count !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_run: status=%b branch=%b iter=%0d cyc=%0d want 0000/0/0/0",
                     status, fsm_branch, iter_count, cycle_count);
        end
        step(); step();
        reset = 1'b0;
        step();
        vectors++;
        if (status !== 4'b0000 || done_cnt - d0 !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done: status=%b dones=%0d want 0000/0", status, done_cnt - d0);
        end
        do_run(2, 2, 3, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        do_run(4, 4, 2, 1'b0, 1'b1, "go_ignored_a");
        do_run(1, 2, 3, 1'b1, 1'b1, "go_ignored_b");
    endtask

    task automatic test_random();
        int  trip;
        int  n_ev;
        int  gap;
        bit  fin_eval;
        bit  poke;
        for (int i = 0; i < 12; i++) begin
            trip     = $urandom_range(1, 6);
            n_ev     = $urandom_range(0, 4);
            gap      = $urandom_range(2, 4);
            fin_eval = (n_ev > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            poke     = 1'($urandom_range(0, 1));
            do_run(trip, n_ev, gap, fin_eval, poke, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_trip();
        test_same_cycle();
        test_timeout();
        test_abort_run();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/loop_sequencer.md
LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 SHALL have parameter TRIP_W, default 8: width of the trip count and iteration counters.
REQ-002 SHALL have parameter CYC_W, default 16: width of the cycle counter.
REQ-003 SHALL have parameter TIMEOUT, default 1000: RUN-state cycle limit before the error state.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port go, input, 1: request one sequenced run; sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1: return to IDLE from any state.
REQ-008 SHALL have port trip_count, input, TRIP_W: number of loop-body passes; latched on accepted go.
REQ-009 SHALL have port fsm_start, output, 1: start pulse to the controlled FSM.
REQ-010 SHALL have port fsm_branch, output, 1: loop-back condition to the controlled FSM (drives its B_ctrl_in0).
REQ-011 SHALL have port fsm_eval, input, 1: one-cycle pulse when the controlled FSM is in its branch-evaluation state.
REQ-012 SHALL have port fsm_finish, input, 1: finish from the controlled FSM.
REQ-013 SHALL have port busy, output, 1: high in LAUNCH and RUN.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1: timeout flag, held in ERR.
REQ-016 SHALL have port iter_count, output, TRIP_W: fsm_eval pulses counted in the current run.
REQ-017 SHALL have port cycle_count, output, CYC_W: cycles from launch to finish, saturating at all-ones.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, RUN, DONE, ERR as a registered FSM.
REQ-019 IDLE: go=1 SHALL latch trip_count into rem, clear iter_count and cycle_count; next state LAUNCH if trip_count!=0, else DONE with no fsm_start.
REQ-020 LAUNCH: fsm_start SHALL be 1 for exactly this one cycle; next state RUN unconditionally.
REQ-021 fsm_branch SHALL be a registered output equal to (rem > 1), updated the cycle after each rem change.
REQ-022 RUN: each fsm_eval pulse SHALL decrement rem (floor 0) and increment iter_count (saturating).
REQ-023 RUN: cycle_count SHALL increment every cycle, including the fsm_finish cycle.
REQ-024 RUN: fsm_finish=1 SHALL go to DONE; an fsm_eval in the same cycle SHALL still be counted.
REQ-025 RUN: cycle_count reaching TIMEOUT without fsm_finish SHALL go to ERR.
REQ-026 DONE: done SHALL be 1 for one cycle; next state IDLE; iter_count and cycle_count SHALL hold until the next accepted go.
REQ-027 ERR: err=1; SHALL remain in ERR until abort or reset; go ignored.
REQ-028 abort=1 in any state SHALL force IDLE next cycle with fsm_start=0, done=0, and err cleared; abort has priority over go, fsm_finish and timeout.
REQ-029 go outside IDLE, and fsm_eval/fsm_finish outside RUN, SHALL be ignored.
REQ-030 Latency: go accepted at edge N SHALL produce fsm_start high in cycle N+1.

Reset
REQ-031 reset SHALL asynchronously force IDLE with rem=0, iter_count=0, cycle_count=0.
REQ-032 During and after reset, fsm_start, fsm_branch, busy, done and err SHALL all be 0.
REQ-033 Reset asserted mid-run SHALL abandon the run without asserting done.

Structure
REQ-034 The state encoding and reset-state constants SHALL live in the shared package loop_ctrl_pkg.
REQ-035 The saturating cycle counter SHALL be the sub-module sat_counter, parameterised by width.
REQ-036 All outputs SHALL be driven from registers; no combinational path from input to output.

Verification
REQ-037 trip_count=3, go, fsm_eval every 4 cycles, fsm_finish after third eval -> fsm_branch 1,1,0 at the evals; iter_count=3; one done pulse.
REQ-038 trip_count=0, go -> no fsm_start, done one cycle later, iter_count=0, cycle_count=0.
REQ-039 trip_count=2, no fsm_finish, TIMEOUT=20 -> err=1 after 20 RUN cycles, held; abort -> IDLE, err=0.
REQ-040 fsm_eval and fsm_finish in the same cycle -> iter_count includes that eval; done next cycle.
REQ-041 reset asserted 5 cycles into RUN -> all outputs 0 immediately, no done; a new go then starts cleanly.
REQ-042 go pulsed during RUN and during DONE -> ignored; exactly one fsm_start per accepted go.
